// File: rtl/bus_pkg.sv
// Shared definitions for the bus round-robin arbiter: FSM states, ID field
// constants and destination extraction.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } state_t;

    localparam int          ID_BITS   = 8;
    localparam logic [7:0]  BROADCAST = 8'hFF;

    // Destination ID sits in the top id_bits of a width-bit word; the word is
    // passed right-aligned in 64 bits so one function serves any bus width.
    function automatic logic [31:0] dest_of(input logic [63:0] word,
                                            input int          width,
                                            input int          id_bits);
        logic [63:0] mask;
        logic [63:0] shifted;
        mask    = (64'd1 << id_bits) - 64'd1;
        shifted = word >> (width - id_bits);
        return 32'(shifted & mask);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority search: first set request at or after ptr, wrapping.
// Purely combinational.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        // Walk from the farthest offset back to ptr so the nearest hit wins.
        for (int k = N - 1; k >= 0; k--) begin
            int p;
            p = (int'(ptr) + k) % N;
            if (req[p]) begin
                valid = 1'b1;
                idx   = PW'(p);
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Shared-bus controller: grants one pending transmit FIFO per 3-cycle
// transaction (IDLE/GRANT/XFER), pops one word and routes it to its destination.
module bus_rr_arbiter #(
    parameter int                     DRVRS     = 4,
    parameter int                     WIDTH     = 16,
    parameter int                     ID_BITS   = bus_pkg::ID_BITS,
    parameter logic [ID_BITS-1:0]     BROADCAST = ID_BITS'(bus_pkg::BROADCAST)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DRVRS-1:0]             pndng_i,
    input  logic [DRVRS-1:0][WIDTH-1:0]  dato_i,
    output logic [DRVRS-1:0]             pop_o,
    output logic [DRVRS-1:0]             push_o,
    output logic [WIDTH-1:0]             dato_o,
    output logic [DRVRS-1:0]             grant_o,
    output logic                         busy_o,
    output logic                         err_o
);
    import bus_pkg::*;

    localparam int PW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

    state_t             state_q;
    state_t             state_nxt;
    logic [PW-1:0]      g_q;
    logic [PW-1:0]      rr_ptr_q;
    logic [PW-1:0]      rr_ptr_nxt;
    logic [WIDTH-1:0]   data_q;
    logic               pick_vld;
    logic [PW-1:0]      pick_idx;
    logic [31:0]        dest;
    logic [DRVRS-1:0]   owner;

    rr_picker #(
        .N  (DRVRS),
        .PW (PW)
    ) u_picker (
        .req   (pndng_i),
        .ptr   (rr_ptr_q),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    assign owner      = DRVRS'(1) << g_q;
    assign dest       = dest_of(64'(data_q), WIDTH, ID_BITS);
    assign rr_ptr_nxt = (g_q == PW'(DRVRS - 1)) ? '0 : g_q + 1'b1;
    assign dato_o     = data_q;
    assign busy_o     = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            g_q      <= '0;
            rr_ptr_q <= '0;
            data_q   <= '0;
        end else begin
            state_q <= state_nxt;
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        g_q <= pick_idx;
                    end
                end
                GRANT: begin
                    if (pndng_i[g_q]) begin
                        data_q <= dato_i[g_q];
                    end
                end
                XFER: begin
                    rr_ptr_q <= rr_ptr_nxt;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state_q;
        grant_o   = '0;
        pop_o     = '0;
        push_o    = '0;
        err_o     = 1'b0;
        case (state_q)
            IDLE: begin
                // The selection is combinational here, so reset must mask it.
                if (pick_vld && !rst) begin
                    grant_o   = DRVRS'(1) << pick_idx;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (pndng_i[g_q]) begin
                    grant_o   = owner;
                    pop_o     = owner;
                    state_nxt = XFER;
                end else begin
                    state_nxt = IDLE;
                end
            end
            XFER: begin
                grant_o = owner;
                if (dest == 32'(BROADCAST)) begin
                    push_o = ~owner;
                end else if (dest < 32'(DRVRS)) begin
                    push_o = DRVRS'(1) << dest[PW-1:0];
                end else begin
                    err_o = 1'b1;
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed self-checking bench for bus_rr_arbiter (DRVRS=4, WIDTH=16).
module tb_bus_rr_arbiter;

    logic              clk;
    logic              rst;
    logic [3:0]        pndng;
    logic [3:0][15:0]  dato;
    logic [3:0]        pop;
    logic [3:0]        push;
    logic [15:0]       bus_dat;
    logic [3:0]        grant;
    logic              busy;
    logic              err;

    int checks;
    int failures;

    bus_rr_arbiter #(
        .DRVRS (4),
        .WIDTH (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pndng_i (pndng),
        .dato_i  (dato),
        .pop_o   (pop),
        .push_o  (push),
        .dato_o  (bus_dat),
        .grant_o (grant),
        .busy_o  (busy),
        .err_o   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from IDLE, checking each of the three cycles.
    task automatic xact(input string tag, input int src, input logic [3:0] exp_push,
                        input logic [15:0] exp_dat, input logic exp_err);
        chk({tag, "_grant"}, 32'(grant), 32'(4'b0001 << src));
        chk({tag, "_idle_pop"}, 32'(pop), 32'h0);
        step();
        chk({tag, "_pop"}, 32'(pop), 32'(4'b0001 << src));
        chk({tag, "_gnt_push"}, 32'(push), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h1);
        step();
        chk({tag, "_push"}, 32'(push), 32'(exp_push));
        chk({tag, "_xfer_pop"}, 32'(pop), 32'h0);
        chk({tag, "_dato"}, 32'(bus_dat), 32'(exp_dat));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        step();
        chk({tag, "_err_clr"}, 32'(err), 32'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        pndng    = 4'b1111;
        dato     = '0;

        // Reset held with requests pending: everything quiet.
        repeat (4) step();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_pop",   32'(pop),   32'h0);
        chk("rst_push",  32'(push),  32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_err",   32'(err),   32'h0);
        chk("rst_dato",  32'(bus_dat), 32'h0);

        // Release, start a transaction for terminal 2, then reset in GRANT.
        rst   = 1'b0;
        pndng = 4'b0100;
        dato[2] = 16'h0122;
        #1;
        chk("pre_abort_grant", 32'(grant), 32'h4);
        step();
        chk("pre_abort_pop", 32'(pop), 32'h4);
        rst = 1'b1;
        #1;
        chk("mid_rst_pop",   32'(pop),   32'h0);
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_busy",  32'(busy),  32'h0);
        step();
        step();
        rst = 1'b0;

        // Round robin with all four pending; dest of terminal i is (i+1)%4.
        pndng   = 4'b1111;
        dato[0] = 16'h01A0;
        dato[1] = 16'h02A1;
        dato[2] = 16'h03A2;
        dato[3] = 16'h00A3;
        #1;
        xact("rr0", 0, 4'b0010, 16'h01A0, 1'b0);
        xact("rr1", 1, 4'b0100, 16'h02A1, 1'b0);
        xact("rr2", 2, 4'b1000, 16'h03A2, 1'b0);
        xact("rr3", 3, 4'b0001, 16'h00A3, 1'b0);
        xact("rr4", 0, 4'b0010, 16'h01A0, 1'b0);

        // Single transfer from terminal 1 (pointer now 1).
        pndng   = 4'b0010;
        dato[1] = 16'h0255;
        #1;
        xact("single", 1, 4'b0100, 16'h0255, 1'b0);
        chk("single_hold_dato", 32'(bus_dat), 32'h0255);

        // Broadcast from terminal 2.
        pndng   = 4'b0100;
        dato[2] = 16'hFF3C;
        #1;
        xact("bcast", 2, 4'b1011, 16'hFF3C, 1'b0);

        // Undeliverable destination 7 from terminal 0 (pointer 3 wraps to 0).
        pndng   = 4'b0001;
        dato[0] = 16'h0711;
        #1;
        xact("baddst", 0, 4'b0000, 16'h0711, 1'b1);

        // Pointer must now be 1: terminals 0,1,3 pending -> 1 wins.
        pndng   = 4'b1011;
        dato[1] = 16'h0200;
        #1;
        xact("ptr_adv", 1, 4'b0100, 16'h0200, 1'b0);

        // Withdrawal: terminal 3 granted from pointer 2, drops in GRANT.
        pndng = 4'b1000;
        #1;
        chk("wd_grant", 32'(grant), 32'h8);
        step();
        pndng = 4'b0000;
        #1;
        chk("wd_pop",   32'(pop),   32'h0);
        chk("wd_grant_drop", 32'(grant), 32'h0);
        step();
        chk("wd_idle_busy", 32'(busy), 32'h0);
        chk("wd_idle_push", 32'(push), 32'h0);

        // Pointer unchanged at 2: terminals 0 and 3 pending -> 3 wins.
        pndng   = 4'b1001;
        dato[3] = 16'h0033;
        #1;
        xact("wd_regrant", 3, 4'b0001, 16'h0033, 1'b0);

        pndng = 4'b0000;
        step();
        chk("end_busy", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
Shared-bus controller for the multi-terminal bus emulator. Each of DRVRS terminals owns a transmit FIFO (width x depth, push/pop interface). This block grants the single shared bus to one pending FIFO at a time in round-robin order, pops one word from it, and routes that word to the destination terminal's receive FIFO (or to all others on broadcast). It is the only block that drives pop_i on transmit FIFOs and push_i on receive FIFOs.

Parameters:
- DRVRS, 4, number of terminals (2..16).
- WIDTH, 16, bus word width; must match the FIFO width.
- ID_BITS, 8, destination-ID field width, located in dato[WIDTH-1 -: ID_BITS].
- BROADCAST, 8'hFF, destination ID meaning "all terminals except the source".

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- pndng_i  input  DRVRS  per-terminal "transmit FIFO not empty".
- dato_i  input  DRVRS x WIDTH  head-of-FIFO word from each transmit FIFO.
- pop_o  output  DRVRS  one-cycle pop strobe to transmit FIFOs.
- push_o  output  DRVRS  one-cycle push strobe to receive FIFOs.
- dato_o  output  WIDTH  shared bus word driven to all receive FIFOs.
- grant_o  output  DRVRS  one-hot current bus owner; 0 when idle.
- busy_o  output  1  high whenever state != IDLE.
- err_o  output  1  one-cycle pulse on an undeliverable destination ID.

Behaviour:
- Reset (async, immediate): state=IDLE, rr_ptr=0, all outputs 0. When rst is deasserted, the block re-enters IDLE with no pending pop or push.
- FSM IDLE -> GRANT -> XFER -> IDLE. One transaction takes 3 cycles; peak throughput is 1 word per 3 clks.
- IDLE:
  - If any pndng_i is set, select the first set bit at or after rr_ptr, wrapping modulo DRVRS.
  - Register g = selected index, drive grant_o=1<<g, go to GRANT.
  - If no pndng_i is set, stay in IDLE.
- GRANT:
  - If pndng_i[g] is still 1: latch dato_i[g] into data_q, assert pop_o[g] for exactly this cycle, go to XFER.
  - If pndng_i[g] has dropped: abort. No pop, grant_o=0, rr_ptr unchanged, go to IDLE.
- XFER:
  - Drive dato_o=data_q. Let dest = data_q[WIDTH-1 -: ID_BITS].
  - If dest==BROADCAST: push_o = all ones except bit g.
  - Else if dest<DRVRS: push_o = 1<<dest. Self-addressing (dest==g) is delivered normally.
  - Else: push_o=0 and err_o=1 for this cycle.
  - In all cases set rr_ptr = (g+1) mod DRVRS, then go to IDLE.
- dato_o holds data_q after XFER until the next XFER. Only push_o qualifies dato_o.
- pop_o and push_o are never both nonzero in the same cycle. At most one pop_o bit is ever high.
- Receive-FIFO full is not back-pressured: the push is issued regardless, and overflow handling belongs to the FIFO.
- Reset asserted in GRANT or XFER: the strobe is killed immediately (async). A word already popped is lost; this is accepted.

Decomposition:
- Package bus_pkg holds:
  - the state enum (IDLE, GRANT, XFER);
  - ID_BITS and BROADCAST constants;
  - a function extracting dest from a word.
- One combinational sub-module, rr_picker (inputs req[DRVRS] and ptr; outputs valid and idx), performs the rotating-priority search. The FSM, registers and routing stay in bus_rr_arbiter.

Test Plan (DRVRS=4, WIDTH=16, ID in [15:8]):
1. Hold rst=1 across several clks, then assert rst mid-transaction -> all outputs 0 within the same cycle; busy_o=0; the next grant after release goes to terminal 0.
2. Single transfer: pndng_i=4'b0010, dato_i[1]=16'h0255.
   - Cycle 1: grant_o=4'b0010.
   - Cycle 2: pop_o=4'b0010.
   - Cycle 3: dato_o=16'h0255, push_o=4'b0100.
3. Round-robin: pndng_i=4'b1111 held, with distinct words per terminal -> grant_o sequence 0001, 0010, 0100, 1000, 0001, spaced 3 clks apart, and no starvation.
4. Broadcast: terminal 2 sends 16'hFF3C -> in XFER, push_o=4'b1011 and dato_o=16'hFF3C.
5. Invalid destination: terminal 0 sends 16'h0711 -> pop_o[0] pulses, push_o stays 0, err_o pulses for 1 cycle, rr_ptr advances to 1.
6. Withdrawal: pndng_i[3] is asserted in IDLE and dropped in the GRANT cycle -> no pop_o, return to IDLE, rr_ptr unchanged, and the next grant re-evaluates from the same pointer.
